seg_serial_rx: RTL and testbench

Serial-to-parallel receiver for the four-wire seven-segment display link (SEGCLK / SEGDT / SEGEN / SEGCLR) driven by the display-output path of the top-level frame. It oversamples the link on the system clock, shifts in one frame of segment bits, and presents the latched frame as a parallel word with a one-cycle valid strobe and a length-error flag. It is the board-side end of the link in synthesizable form. It is used as an on-chip loopback monitor and as the checker model in frame-level simulation.

---
 rtl/seg_serial_rx_if.sv | 26 ++
 rtl/seg_serial_rx.sv | 132 +++++++++++++
 tb/tb_seg_serial_rx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_serial_rx_if.sv
// Seven-segment serial link bundle: four link wires in, latched frame word and status out.
// master drives the link and observes the frame; slave is the receiver.
interface seg_serial_rx_if #(
    parameter int N_BITS = 64,
    parameter int CNT_W  = 7
);
    logic              seg_clk;
    logic              seg_dt;
    logic              seg_en;
    logic              seg_clr;
    logic [N_BITS-1:0] frame;
    logic              frame_vld;
    logic              frame_err;
    logic [CNT_W-1:0]  bit_cnt;
    logic [7:0]        err_cnt;

    modport master (
        output seg_clk, seg_dt, seg_en, seg_clr,
        input  frame, frame_vld, frame_err, bit_cnt, err_cnt
    );

    modport slave (
        input  seg_clk, seg_dt, seg_en, seg_clr,
        output frame, frame_vld, frame_err, bit_cnt, err_cnt
    );
endinterface

// File: rtl/seg_serial_rx.sv
// Oversampling receiver for the SEGCLK/SEGDT/SEGEN/SEGCLR link; SEG_RX_ERRCNT_EN adds an errored-frame counter.
// Latency: shift lands 3 clk_100mhz edges after a seg_clk rise; frame_vld is high in the 4th cycle after a seg_en rise.
// Backpressure: none; the link is push-only and every latch is presented for exactly one cycle.
module seg_serial_rx #(
    parameter int N_BITS = 64,
    parameter int CNT_W  = 7
) (
    input  logic           clk_100mhz,
    input  logic           rst,
    seg_serial_rx_if.slave link
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_BITS);

    // seg_clk and seg_en need a history flop for edge detection; data and
    // clear are level-sampled, so they stop after the two sync stages.
    logic [2:0]        clk_sh;
    logic [2:0]        en_sh;
    logic [1:0]        dt_sh;
    logic [1:0]        clr_sh;
    logic              clk_rise;
    logic              en_rise;
    logic              dt_sync;
    logic              clr_sync;

    state_t            state;
    logic [N_BITS-1:0] shreg;
    logic [N_BITS-1:0] shreg_nx;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nx;
    logic [N_BITS-1:0] frame_q;
    logic              frame_vld_q;
    logic              frame_err_q;
    logic              latch_go;
    logic              err_nx;

    assign clk_rise = clk_sh[1] & ~clk_sh[2];
    assign en_rise  = en_sh[1] & ~en_sh[2];
    assign dt_sync  = dt_sh[1];
    assign clr_sync = clr_sh[1];

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            clk_sh <= '0;
            en_sh  <= '0;
            dt_sh  <= '0;
            clr_sh <= '1;
        end else begin
            clk_sh <= {clk_sh[1:0], link.seg_clk};
            en_sh  <= {en_sh[1:0], link.seg_en};
            dt_sh  <= {dt_sh[0], link.seg_dt};
            clr_sh <= {clr_sh[0], link.seg_clr};
        end
    end

    // Post-shift view, so a latch on the same edge as a shift includes that bit.
    always_comb begin
        shreg_nx = shreg;
        cnt_nx   = cnt_q;
        if (clk_rise) begin
            shreg_nx = {shreg[N_BITS-2:0], dt_sync};
            cnt_nx   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign latch_go = clr_sync && en_rise && (state != LATCH);
    assign err_nx   = (cnt_nx != CNT_FULL);

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt_q       <= '0;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_vld_q <= 1'b0;
            if (!clr_sync) begin
                state <= IDLE;
                shreg <= '0;
                cnt_q <= '0;
            end else begin
                case (state)
                    IDLE, SHIFT: begin
                        if (en_rise) begin
                            state       <= LATCH;
                            shreg       <= shreg_nx;
                            cnt_q       <= '0;
                            frame_q     <= shreg_nx;
                            frame_err_q <= err_nx;
                            frame_vld_q <= 1'b1;
                        end else if (clk_rise) begin
                            state <= SHIFT;
                            shreg <= shreg_nx;
                            cnt_q <= cnt_nx;
                        end
                    end
                    LATCH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SEG_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (latch_go && err_nx && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign link.err_cnt = err_cnt_q;
`else
    assign link.err_cnt = 8'd0;
`endif

    assign link.frame     = frame_q;
    assign link.frame_vld = frame_vld_q;
    assign link.frame_err = frame_err_q;
    assign link.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_seg_serial_rx.sv
// Randomized bench for seg_serial_rx: a bit-history model predicts each latched frame,
// a scoreboard queue holds predictions and a negedge monitor compares on every frame_vld.
module tb_seg_serial_rx;
    localparam int NB = 64;
    localparam int CW = 7;

    typedef struct {
        logic [NB-1:0] frame;
        logic          err;
        logic [7:0]    ecnt;
        int            cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    exp_t exp_q[$];

    // Model: bits received since the last clear/reset (newest at the back),
    // bits counted since the last latch/clear, and the errored-frame tally.
    bit            hist[$];
    int            cnt;
    int            nerr;
    logic [NB-1:0] last_frame;

    seg_serial_rx_if #(.N_BITS(NB), .CNT_W(CW)) link ();

    seg_serial_rx #(.N_BITS(NB), .CNT_W(CW)) dut (
        .clk_100mhz (clk),
        .rst        (rst),
        .link       (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] model_frame();
        logic [NB-1:0] f;
        int n;
        f = '0;
        n = hist.size();
        for (int i = 0; i < NB; i++) begin
            if (n - 1 - i >= 0) f[i] = hist[n-1-i];
        end
        return f;
    endfunction

    task automatic model_push(input bit b);
        hist.push_back(b);
        if (hist.size() > NB) void'(hist.pop_front());
        if (cnt < (1 << CW) - 1) cnt++;
    endtask

    task automatic model_latch();
        exp_t e;
        e.frame = model_frame();
        e.err   = (cnt != NB);
        if (e.err && nerr < 255) nerr++;
`ifdef SEG_RX_ERRCNT_EN
        e.ecnt = 8'(nerr);
`else
        e.ecnt = 8'd0;
`endif
        e.cyc = cyc + 3;
        exp_q.push_back(e);
        cnt = 0;
        last_frame = e.frame;
    endtask

    task automatic send_bit(input bit b, input bit with_en);
        link.seg_dt = b;
        tick(4);
        link.seg_clk = 1'b1;
        if (with_en) link.seg_en = 1'b1;
        model_push(b);
        if (with_en) model_latch();
        tick(4);
        check("bit_cnt", NB'(link.bit_cnt), NB'(cnt));
        link.seg_clk = 1'b0;
        if (with_en) begin
            link.seg_en = 1'b0;
            tick(4);
        end
    endtask

    task automatic send_word(input logic [NB-1:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(d[i], 1'b0);
    endtask

    task automatic pulse_en();
        link.seg_en = 1'b1;
        model_latch();
        tick(4);
        link.seg_en = 1'b0;
        tick(4);
        check("bit_cnt_after_latch", NB'(link.bit_cnt), '0);
    endtask

    task automatic pulse_clr(input int n);
        link.seg_clr = 1'b0;
        hist.delete();
        cnt = 0;
        tick(n);
        check("frame_during_clear", link.frame, last_frame);
        link.seg_clr = 1'b1;
        tick(4);
        check("bit_cnt_after_clear", NB'(link.bit_cnt), '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        hist.delete();
        cnt = 0;
        nerr = 0;
        last_frame = '0;
        check("rst_frame", link.frame, '0);
        check("rst_frame_vld", NB'(link.frame_vld), '0);
        check("rst_frame_err", NB'(link.frame_err), '0);
        check("rst_bit_cnt", NB'(link.bit_cnt), '0);
        check("rst_err_cnt", NB'(link.err_cnt), '0);
    endtask

    // Monitor: pops one prediction per frame_vld and checks pulse width.
    initial begin
        logic prev_vld;
        exp_t e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (link.frame_vld === 1'b1) begin
                check("vld_width", NB'(prev_vld), '0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_vld: frame_vld=1 with no frame pending, expected 0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", link.frame, e.frame);
                    check("frame_err", NB'(link.frame_err), NB'(e.err));
                    check("err_cnt", NB'(link.err_cnt), NB'(e.ecnt));
                    check("vld_cycle", NB'(cyc), NB'(e.cyc));
                end
            end
            prev_vld = link.frame_vld;
        end
    end

    initial begin
        logic [NB-1:0] w;
        int len;
        int guard;

        total = 0;
        bad = 0;
        cnt = 0;
        nerr = 0;
        last_frame = '0;
        rst = 1'b1;
        link.seg_clk = 1'b0;
        link.seg_dt  = 1'b0;
        link.seg_en  = 1'b0;
        link.seg_clr = 1'b1;
        tick(3);
        do_reset();

        // Nominal frame
        w = 64'hC0F9_A4B0_9992_82F8;
        send_word(w, 64);
        pulse_en();

        // Short (63) and long (66) frames
        w = {$urandom, $urandom};
        send_word(w, 63);
        pulse_en();
        send_word(64'($urandom_range(0, 3)), 2);
        w = {$urandom, $urandom};
        send_word(w, 64);
        pulse_en();

        // Clear mid-frame, then all ones
        w = {$urandom, $urandom};
        send_word(w, 20);
        pulse_clr(5);
        send_word('1, 64);
        pulse_en();

        // Last bit's clock edge and the latch strobe on the same cycle
        w = {$urandom, $urandom};
        send_word(w, 63);
        send_bit(bit'($urandom_range(0, 1)), 1'b1);

        // Reset mid-frame, then a full frame
        w = {$urandom, $urandom};
        send_word(w, 30);
        do_reset();
        w = {$urandom, $urandom};
        send_word(w, 64);
        pulse_en();

        // Random frames: mostly full length, some short/long, occasional clears
        for (int k = 0; k < 10; k++) begin
            w = {$urandom, $urandom};
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 70)) : 64;
            if (len > 64) begin
                send_word(64'($urandom), len - 64);
                send_word(w, 64);
            end else begin
                send_word(w, len);
            end
            if ($urandom_range(0, 4) == 0) pulse_clr(3 + int'($urandom_range(0, 3)));
            else pulse_en();
            tick(int'($urandom_range(0, 5)));
        end

        // Error-counter saturation with single-bit frames
        for (int k = 0; k < 260; k++) begin
            send_bit(bit'($urandom_range(0, 1)), 1'b0);
            pulse_en();
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            tick(1);
            guard++;
        end
        check("pending_frames", NB'(exp_q.size()), '0);
`ifdef SEG_RX_ERRCNT_EN
        check("err_cnt_final", NB'(link.err_cnt), NB'(8'(nerr)));
`else
        check("err_cnt_final", NB'(link.err_cnt), '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
